// File: rtl/alu_mem_core_pkg.sv
// Shared definitions for the ALU / memory core.
// Contents:
//   DATA_W    - width of ALU operands, results and data-memory words
//   INSTR_W   - width of instruction-memory words
//   alu_op_e  - encodings carried on alu_sel
package alu_mem_core_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage : alu_mem_core_pkg

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU.
// Ports:
//   a, b   - operands
//   sel    - operation (see alu_op_e)
//   result - a op b, wrapping modulo 2^DATA_W; no carry or overflow is produced
//   zero   - high when result is all zeros
module alu_core
  import alu_mem_core_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (alu_op_e'(sel))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule : alu_core

// File: rtl/alu_mem_core.sv
// ALU plus instruction and data memories.
// Ports:
//   clk, reset        - rising-edge clock; synchronous active-high reset that
//                       clears every word of both memories
//   pc                - byte address; fetch uses word pc[IA_W:1], other bits ignored
//   instruction       - combinational fetch result
//   imem_we/addr/wdata- instruction-memory load port (written on clk edge)
//   alu_a/b/sel       - ALU operands and operation
//   alu_result/zero   - ALU outputs; alu_result also addresses data memory
//   dmem_write/wdata  - data-memory write at mem[alu_result] on clk edge
//   dmem_read/rdata   - combinational read of mem[alu_result], 0 when not reading
module alu_mem_core
  import alu_mem_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 256
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   pc,
  output logic [INSTR_W-1:0]            instruction,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [INSTR_W-1:0]            imem_wdata,
  input  logic [DATA_W-1:0]             alu_a,
  input  logic [DATA_W-1:0]             alu_b,
  input  logic [1:0]                    alu_sel,
  output logic [DATA_W-1:0]             alu_result,
  output logic                          alu_zero,
  input  logic                          dmem_write,
  input  logic                          dmem_read,
  input  logic [DATA_W-1:0]             dmem_wdata,
  output logic [DATA_W-1:0]             dmem_rdata
);

  localparam int IA_W = $clog2(IMEM_DEPTH);

  logic [INSTR_W-1:0] imem_reg [IMEM_DEPTH];
  logic [DATA_W-1:0]  dmem_reg [DMEM_DEPTH];

  logic [IA_W-1:0] fetch_idx;

  alu_core u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Instruction memory: the word index drops pc[0] (byte address of 16-bit
  // words) and all bits above the array size, so fetches wrap.
  assign fetch_idx   = pc[IA_W:1];
  assign instruction = imem_reg[fetch_idx];

  // Reset clears the whole array in one edge and wins over a pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem_reg[i] <= '0;
    end else if (imem_we) begin
      imem_reg[imem_addr] <= imem_wdata;
    end
  end

  // Data memory: addressed directly by the 8-bit ALU result, which spans
  // exactly the DMEM_DEPTH words.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_reg[i] <= '0;
    end else if (dmem_write) begin
      dmem_reg[alu_result] <= dmem_wdata;
    end
  end

  // Asynchronous read shows stored contents, so a same-cycle write is only
  // visible after the edge.
  assign dmem_rdata = dmem_read ? dmem_reg[alu_result] : '0;

endmodule : alu_mem_core

// File: tb/tb_alu_mem_core.sv
module tb_alu_mem_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        dmem_write, dmem_read;
  logic [7:0]  dmem_wdata, dmem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mem_core #(.IMEM_DEPTH(16), .DMEM_DEPTH(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .dmem_write  (dmem_write),
    .dmem_read   (dmem_read),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and return on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc = '0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    alu_a = '0; alu_b = '0; alu_sel = 2'b00;
    dmem_write = 1'b0; dmem_read = 1'b0; dmem_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dmem_read = 1'b1;
    #1;
    check("rst_instr", instruction, 16'h0000);
    check("rst_rdata", {8'h00, dmem_rdata}, 16'h0000);
    check("rst_zero", {15'd0, alu_zero}, 16'h0001);
    dmem_read = 1'b0;

    // ALU
    alu_a = 8'hF0; alu_b = 8'h20; alu_sel = 2'b00; #1;
    check("add_wrap", {8'h00, alu_result}, 16'h0010);
    check("add_zero", {15'd0, alu_zero}, 16'h0000);
    alu_a = 8'h05; alu_b = 8'h05; alu_sel = 2'b01; #1;
    check("sub_eq", {8'h00, alu_result}, 16'h0000);
    check("sub_zero", {15'd0, alu_zero}, 16'h0001);
    alu_a = 8'h03; alu_b = 8'h05; alu_sel = 2'b01; #1;
    check("sub_borrow", {8'h00, alu_result}, 16'h00FE);
    alu_a = 8'hCC; alu_b = 8'hAA; alu_sel = 2'b10; #1;
    check("and", {8'h00, alu_result}, 16'h0088);
    alu_sel = 2'b11; #1;
    check("or", {8'h00, alu_result}, 16'h00EE);

    // Data memory write then read at 0x10+0x03 = 0x13
    @(negedge clk);
    alu_a = 8'h10; alu_b = 8'h03; alu_sel = 2'b00;
    dmem_write = 1'b1; dmem_wdata = 8'h5A; dmem_read = 1'b0;
    cycle();
    dmem_write = 1'b0; dmem_read = 1'b1; #1;
    check("dm_read", {8'h00, dmem_rdata}, 16'h005A);
    dmem_read = 1'b0; #1;
    check("dm_noread", {8'h00, dmem_rdata}, 16'h0000);
    alu_b = 8'h02; dmem_read = 1'b1; #1;
    check("dm_other", {8'h00, dmem_rdata}, 16'h0000);
    dmem_read = 1'b0;

    // Instruction memory load of word 3
    @(negedge clk);
    imem_we = 1'b1; imem_addr = 4'd3; imem_wdata = 16'hA5C3; pc = 16'd6; #1;
    check("im_old", instruction, 16'h0000);
    cycle();
    imem_we = 1'b0; #1;
    check("im_pc6", instruction, 16'hA5C3);
    pc = 16'd7; #1;
    check("im_pc7", instruction, 16'hA5C3);
    pc = 16'd38; #1;
    check("im_pc38", instruction, 16'hA5C3);
    pc = 16'd8; #1;
    check("im_pc8", instruction, 16'h0000);

    // Read-during-write at 0x10
    @(negedge clk);
    alu_a = 8'h10; alu_b = 8'h00; alu_sel = 2'b00;
    dmem_write = 1'b1; dmem_wdata = 8'h5A;
    cycle();
    dmem_wdata = 8'h77; dmem_read = 1'b1; #1;
    check("rdw_before", {8'h00, dmem_rdata}, 16'h005A);
    @(posedge clk); #1;
    check("rdw_after", {8'h00, dmem_rdata}, 16'h0077);
    @(negedge clk);
    dmem_write = 1'b0;
    alu_b = 8'h03; #1;
    check("dm_keep13", {8'h00, dmem_rdata}, 16'h005A);

    // Reset with pending writes; ALU keeps working during reset
    reset = 1'b1; dmem_write = 1'b1; dmem_wdata = 8'hFF;
    imem_we = 1'b1; imem_addr = 4'd3; imem_wdata = 16'h1234;
    alu_a = 8'hF0; alu_b = 8'h20; alu_sel = 2'b00; #1;
    check("alu_in_rst", {8'h00, alu_result}, 16'h0010);
    cycle();
    reset = 1'b0; dmem_write = 1'b0; imem_we = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      pc = 16'(2 * i); #1;
      check($sformatf("rst2_im%0d", i), instruction, 16'h0000);
    end
    alu_b = 8'h00; alu_sel = 2'b11; dmem_read = 1'b1;
    for (int i = 0; i < 256; i++) begin
      alu_a = 8'(i); #1;
      check($sformatf("rst2_dm%02h", i), {8'h00, dmem_rdata}, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_mem_core
